// File: rtl/rv_fmt_pkg.sv
// Shared RV32I format definitions: 3-bit immediate format codes, common opcodes,
// and a signed-fit helper used by both the immediate generator and the encoder.
package rv_fmt_pkg;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_SB = 3'd3,
        FMT_UJ = 3'd4,
        FMT_U  = 3'd5
    } imm_type_t;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    // True when value is representable as a 'bits'-wide two's complement number,
    // i.e. every bit from position bits-1 upward equals the sign bit.
    function automatic logic fits_signed(input logic [31:0] value, input int unsigned bits);
        logic [31:0] hi;
        hi = $signed(value) >>> (bits - 1);
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational check that an immediate fits, and is suitably aligned for,
// the instruction format it is about to be packed into.
module imm_range_check
    import rv_fmt_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic        err
);

    always_comb begin
        err = 1'b1;
        case (fmt)
            FMT_R:         err = 1'b0;
            FMT_I, FMT_S:  err = !fits_signed(imm, 12);
            FMT_SB:        err = !fits_signed(imm, 13) || imm[0];
            FMT_UJ:        err = !fits_signed(imm, 21) || imm[0];
            FMT_U:         err = |imm[11:0];
            default:       err = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RV32I instruction encoder: S1 captures the request and
// range-checks the immediate, S2 holds the packed word, error flag and error count.
module inst_encoder
    import rv_fmt_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           type_i,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [31:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          inst,
    output logic                 imm_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    logic        s1_valid_reg;
    logic [2:0]  s1_type_reg;
    logic [6:0]  s1_opcode_reg;
    logic [4:0]  s1_rd_reg;
    logic [4:0]  s1_rs1_reg;
    logic [4:0]  s1_rs2_reg;
    logic [2:0]  s1_funct3_reg;
    logic [6:0]  s1_funct7_reg;
    logic [31:0] s1_imm_reg;

    logic                 s2_valid_reg;
    logic [31:0]          inst_reg;
    logic                 imm_err_reg;
    logic [ERR_CNT_W-1:0] err_count_reg;

    logic        s1_adv;
    logic        s2_adv;
    logic        s1_err;
    logic [31:0] packed_next;

    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = !s1_valid_reg || s2_adv;
    assign in_ready = s1_adv;

    imm_range_check u_range_check (
        .fmt (s1_type_reg),
        .imm (s1_imm_reg),
        .err (s1_err)
    );

    // Out-of-range immediates are still packed, simply truncated to the field.
    always_comb begin
        packed_next = {25'b0, s1_opcode_reg};
        case (s1_type_reg)
            FMT_R:  packed_next = {s1_funct7_reg, s1_rs2_reg, s1_rs1_reg, s1_funct3_reg,
                                   s1_rd_reg, s1_opcode_reg};
            FMT_I:  packed_next = {s1_imm_reg[11:0], s1_rs1_reg, s1_funct3_reg,
                                   s1_rd_reg, s1_opcode_reg};
            FMT_S:  packed_next = {s1_imm_reg[11:5], s1_rs2_reg, s1_rs1_reg, s1_funct3_reg,
                                   s1_imm_reg[4:0], s1_opcode_reg};
            FMT_SB: packed_next = {s1_imm_reg[12], s1_imm_reg[10:5], s1_rs2_reg, s1_rs1_reg,
                                   s1_funct3_reg, s1_imm_reg[4:1], s1_imm_reg[11],
                                   s1_opcode_reg};
            FMT_UJ: packed_next = {s1_imm_reg[20], s1_imm_reg[10:1], s1_imm_reg[11],
                                   s1_imm_reg[19:12], s1_rd_reg, s1_opcode_reg};
            FMT_U:  packed_next = {s1_imm_reg[31:12], s1_rd_reg, s1_opcode_reg};
            default: packed_next = {25'b0, s1_opcode_reg};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_type_reg   <= '0;
            s1_opcode_reg <= '0;
            s1_rd_reg     <= '0;
            s1_rs1_reg    <= '0;
            s1_rs2_reg    <= '0;
            s1_funct3_reg <= '0;
            s1_funct7_reg <= '0;
            s1_imm_reg    <= '0;
        end else if (s1_adv) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_type_reg   <= type_i;
                s1_opcode_reg <= opcode;
                s1_rd_reg     <= rd;
                s1_rs1_reg    <= rs1;
                s1_rs2_reg    <= rs2;
                s1_funct3_reg <= funct3;
                s1_funct7_reg <= funct7;
                s1_imm_reg    <= imm;
            end
        end
    end

    // The output word only changes when S2 is free to advance, so it holds under stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            inst_reg     <= '0;
            imm_err_reg  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                inst_reg    <= packed_next;
                imm_err_reg <= s1_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_reg <= '0;
        end else if (s2_valid_reg && out_ready && imm_err_reg &&
                     (err_count_reg != {ERR_CNT_W{1'b1}})) begin
            err_count_reg <= err_count_reg + ERR_CNT_W'(1);
        end
    end

    assign out_valid = s2_valid_reg;
    assign inst      = inst_reg;
    assign imm_err   = imm_err_reg;
    assign err_count = err_count_reg;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed-vector bench for inst_encoder: reset, streaming, error flags,
// random backpressure, counter saturation and reset with words in flight.
module tb_inst_encoder;
    import rv_fmt_pkg::*;

    typedef struct {
        logic [2:0]  t;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  type_i = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] inst;
    logic        imm_err;
    logic [15:0] err_count;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [31:0] inst2;
    logic        imm_err2;
    logic [1:0]  err_count2;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    inst_encoder #(.ERR_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .type_i(type_i), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .inst(inst),
        .imm_err(imm_err), .err_count(err_count)
    );

    inst_encoder #(.ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .type_i(type_i), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid2), .out_ready(out_ready2), .inst(inst2),
        .imm_err(imm_err2), .err_count(err_count2)
    );

    function automatic vec_t mk(input logic [2:0] t, input logic [6:0] op,
                                input logic [4:0] rdv, input logic [4:0] rs1v,
                                input logic [4:0] rs2v, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] immv,
                                input logic [31:0] exp_inst, input logic exp_err);
        vec_t v;
        v.t = t; v.op = op; v.rd = rdv; v.rs1 = rs1v; v.rs2 = rs2v;
        v.f3 = f3; v.f7 = f7; v.imm = immv; v.exp_inst = exp_inst; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        type_i = v.t; opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        drive(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0));
        for (int c = 0; c < 3; c++) begin
            #4;
            n_cmp++;
            if (out_valid !== 1'b0 || err_count !== 16'd0 || inst !== 32'd0 || imm_err !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state: out_valid=%b err_count=%0d inst=%h imm_err=%b required 0/0/0/0",
                         out_valid, err_count, inst, imm_err);
            end
            n_cmp++;
            if (out_valid2 !== 1'b0 || err_count2 !== 2'd0) begin
                n_bad++;
                $display("FAIL reset_state_sat: out_valid=%b err_count=%0d required 0/0", out_valid2, err_count2);
            end
            tick();
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = (c == 0);
            #4;
            n_cmp++;
            if (out_valid !== (c == 2)) begin
                n_bad++;
                $display("FAIL reset_release_valid c=%0d: got %b required %b", c, out_valid, (c == 2));
            end
            if (c == 2) begin
                n_cmp++;
                if (inst !== 32'h00500093) begin
                    n_bad++;
                    $display("FAIL reset_release_inst: got %h required 00500093", inst);
                end
            end
            tick();
        end
        $display("reset: release latency checked");
    endtask

    task automatic test_stream();
        vq.delete();
        vq.push_back(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,         32'h00500093, 1'b0));
        vq.push_back(mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         32'h0020A423, 1'b0));
        vq.push_back(mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC,  32'hFE000EE3, 1'b0));
        vq.push_back(mk(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h001000EF, 1'b0));
        vq.push_back(mk(3'd5, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000,  32'h123452B7, 1'b0));
        out_ready = 1'b1;
        for (int c = 0; c < vq.size() + 2; c++) begin
            in_valid = (c < vq.size());
            if (c < vq.size()) drive(vq[c]);
            #4;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL stream_in_ready c=%0d: got %b required 1", c, in_ready);
            end
            n_cmp++;
            if (out_valid !== (c >= 2)) begin
                n_bad++;
                $display("FAIL stream_valid c=%0d: got %b required %b", c, out_valid, (c >= 2));
            end else if (c >= 2) begin
                n_cmp++;
                if (inst !== vq[c-2].exp_inst || imm_err !== vq[c-2].exp_err) begin
                    n_bad++;
                    $display("FAIL stream_word %0d: got %h err=%b required %h err=%b",
                             c - 2, inst, imm_err, vq[c-2].exp_inst, vq[c-2].exp_err);
                end else begin
                    $display("stream word %0d: inst=%h err=%b", c - 2, inst, imm_err);
                end
            end
            tick();
        end
    endtask

    task automatic test_errors();
        vq.delete();
        vq.push_back(mk(3'd1, 7'h13, 5'd1,  5'd0,  5'd0,  3'd0, 7'd0,  32'd2048,     32'h80000093, 1'b1));
        vq.push_back(mk(3'd3, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'd0,  32'd6,        32'h00000363, 1'b0));
        vq.push_back(mk(3'd3, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'd0,  32'd5,        32'h00000263, 1'b1));
        vq.push_back(mk(3'd5, 7'h37, 5'd0,  5'd0,  5'd0,  3'd0, 7'd0,  32'h00001001, 32'h00001037, 1'b1));
        vq.push_back(mk(3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFFFFFF, 32'h0000007F, 1'b1));
        out_ready = 1'b1;
        for (int c = 0; c < vq.size() + 2; c++) begin
            in_valid = (c < vq.size());
            if (c < vq.size()) drive(vq[c]);
            #4;
            n_cmp++;
            if (out_valid !== (c >= 2)) begin
                n_bad++;
                $display("FAIL error_valid c=%0d: got %b required %b", c, out_valid, (c >= 2));
            end else if (c >= 2) begin
                n_cmp++;
                if (inst !== vq[c-2].exp_inst || imm_err !== vq[c-2].exp_err) begin
                    n_bad++;
                    $display("FAIL error_word %0d: got %h err=%b required %h err=%b",
                             c - 2, inst, imm_err, vq[c-2].exp_inst, vq[c-2].exp_err);
                end else begin
                    $display("error word %0d: inst=%h err=%b", c - 2, inst, imm_err);
                end
            end
            tick();
        end
        #4;
        n_cmp++;
        if (err_count !== 16'd4) begin
            n_bad++;
            $display("FAIL error_count: got %0d required 4", err_count);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_q[200];
        logic [31:0] held;
        logic        stalled;
        logic        fire_in;
        logic        exp_rdy;
        int sent, rcvd, cyc;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] iv;
            iv = 32'(i * 7 - 600);
            exp_q[i] = ((iv & 32'hFFF) << 20) | (32'((i * 3) % 32) << 15) |
                       (32'(i % 8) << 12) | (32'(i % 32) << 7) | 32'h13;
        end
        sent = 0; rcvd = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (rcvd < 200 && cyc < 4000) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid = (sent < 200);
            if (sent < 200)
                drive(mk(3'd1, 7'h13, 5'(sent % 32), 5'((sent * 3) % 32), 5'd9,
                         3'(sent % 8), 7'h55, 32'(sent * 7 - 600), 32'd0, 1'b0));
            #4;
            if (stalled) begin
                n_cmp++;
                if (out_valid !== 1'b1 || inst !== held) begin
                    n_bad++;
                    $display("FAIL bp_stall_hold: valid=%b inst=%h required 1 %h", out_valid, inst, held);
                end
            end
            exp_rdy = !((sent - rcvd) == 2 && !out_ready);
            n_cmp++;
            if (in_ready !== exp_rdy) begin
                n_bad++;
                $display("FAIL bp_in_ready cyc=%0d: got %b required %b", cyc, in_ready, exp_rdy);
            end
            fire_in = in_valid && in_ready;
            if (out_valid && out_ready) begin
                n_cmp++;
                if (inst !== exp_q[rcvd] || imm_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_word %0d: got %h err=%b required %h err=0", rcvd, inst, imm_err, exp_q[rcvd]);
                end
                rcvd++;
            end
            stalled = out_valid && !out_ready;
            held = inst;
            tick();
            if (fire_in) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_cmp++;
        if (rcvd != 200) begin
            n_bad++;
            $display("FAIL bp_timeout: received %0d required 200", rcvd);
        end
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_extra_word: out_valid=%b required 0", out_valid);
        end
        $display("backpressure: %0d words received in %0d cycles", rcvd, cyc);
    endtask

    task automatic test_saturation();
        int exp_cnt;
        drive(mk(3'd7, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b1));
        out_ready2 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid2 = (c < 6);
            #4;
            exp_cnt = (c < 2) ? 0 : ((c - 2 > 3) ? 3 : c - 2);
            n_cmp++;
            if (err_count2 !== 2'(exp_cnt)) begin
                n_bad++;
                $display("FAIL sat_count c=%0d: got %0d required %0d", c, err_count2, exp_cnt);
            end
            tick();
        end
        in_valid2 = 1'b0;
        #4;
        n_cmp++;
        if (err_count2 !== 2'd3) begin
            n_bad++;
            $display("FAIL sat_final: got %0d required 3", err_count2);
        end
        $display("saturation: err_count=%0d after 6 errors", err_count2);
        tick();
    endtask

    task automatic test_midstream_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            drive(mk(3'd1, 7'h13, 5'(c + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(c + 1), 32'd0, 1'b0));
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #4;
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_full: out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
        end
        tick();
        rst = 1'b0;
        #4;
        n_cmp++;
        if (out_valid !== 1'b0 || err_count !== 16'd0) begin
            n_bad++;
            $display("FAIL mid_reset: out_valid=%b err_count=%0d required 0/0", out_valid, err_count);
        end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #4;
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL mid_no_emit c=%0d: out_valid=%b required 0", c, out_valid);
            end
            tick();
        end
        $display("midstream reset: pending words discarded");
    endtask

    initial begin
        tick();
        test_reset();
        test_stream();
        test_errors();
        test_backpressure();
        test_saturation();
        test_midstream_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
